// File: rtl/simon_seq_engine_pkg.sv
// Shared types and constants for the Simon sequence engine.
package simon_seq_engine_pkg;

  typedef enum logic [2:0] {
    IDLE, LATCH, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, FAIL
  } simon_state_t;

  typedef enum logic {
    MODE_FOLLOW, MODE_COMMAND
  } game_mode_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit LFSR with seed load and colour
// reduction into the range 0..NUM_COLORS-1.
module simon_lfsr
  import simon_seq_engine_pkg::*;
#(
  parameter int NUM_COLORS = 4,
  localparam int COLOR_W = $clog2(NUM_COLORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [15:0]        seed,
  output logic [COLOR_W-1:0] color
);

  logic [15:0]        lfsr;
  logic [COLOR_W-1:0] raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= LFSR_DEFAULT_SEED;
    else if (load)
      lfsr <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    else
      lfsr <= lfsr_next(lfsr);
  end

  assign raw = lfsr[COLOR_W-1:0];

  // raw < 2*NUM_COLORS, so a single subtraction folds it in range
  assign color = (int'(raw) >= NUM_COLORS)
               ? COLOR_W'(int'(raw) - NUM_COLORS)
               : raw;

endmodule

// File: rtl/simon_seq_engine.sv
// Simon/Genius game engine: sequence storage, playback timing,
// player checking and scoring for a generic colour count.
module simon_seq_engine
  import simon_seq_engine_pkg::*;
#(
  parameter int NUM_COLORS     = 4,
  parameter int MAX_LEN        = 32,
  parameter int FAST_CYCLES    = 25,
  parameter int SLOW_CYCLES    = 50,
  parameter int TIMEOUT_CYCLES = 500,
  localparam int COLOR_W = $clog2(NUM_COLORS),
  localparam int SCORE_W = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  speed,
  input  logic [1:0]            level,
  input  logic [15:0]           seed,
  input  logic                  btn_valid,
  input  logic [COLOR_W-1:0]    btn_color,
  output logic [NUM_COLORS-1:0] led,
  output logic                  busy,
  output logic [SCORE_W-1:0]    score,
  output logic                  win,
  output logic                  fail
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int PH_MAX =
    (FAST_CYCLES > SLOW_CYCLES) ? FAST_CYCLES : SLOW_CYCLES;
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > PH_MAX) ? TIMEOUT_CYCLES : PH_MAX;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  simon_state_t       state, state_n;
  game_mode_t         mode_q;
  logic               speed_q;
  logic [SCORE_W-1:0] target, len;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt, phase_last;
  logic [COLOR_W-1:0] mem [MAX_LEN];
  logic [COLOR_W-1:0] gen_color, add_color;
  logic               phase_done, to_done;
  logic               color_ok, hit, last, add_take;

  function automatic logic [SCORE_W-1:0] target_of(
    input logic [1:0] lv
  );
    int t;
    t = (lv == 2'b11) ? MAX_LEN : (8 << lv);
    if (t > MAX_LEN) t = MAX_LEN;
    return SCORE_W'(t);
  endfunction

  simon_lfsr #(.NUM_COLORS(NUM_COLORS)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (state == LATCH),
    .seed  (seed),
    .color (gen_color)
  );

  assign phase_last = speed_q ? CNT_W'(FAST_CYCLES - 1)
                              : CNT_W'(SLOW_CYCLES - 1);
  assign phase_done = (cnt == phase_last);
  assign to_done    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign color_ok   = (int'(btn_color) < NUM_COLORS);
  assign hit        = color_ok && (btn_color == mem[idx]);
  assign last       = (SCORE_W'(idx) + 1'b1 == len);
  assign add_take   = (mode_q == MODE_COMMAND)
                    ? (btn_valid && color_ok) : 1'b1;
  assign add_color  = (mode_q == MODE_COMMAND) ? btn_color : gen_color;
  assign busy       = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start) state_n = LATCH;
      LATCH:    state_n = ADD;
      ADD:      if (add_take) state_n = SHOW_ON;
      SHOW_ON:  if (phase_done) state_n = SHOW_OFF;
      SHOW_OFF: if (phase_done) state_n = last ? INPUT : SHOW_ON;
      INPUT: begin
        // a press on the expiry cycle takes priority over the timeout
        if (btn_valid) begin
          if (!hit)              state_n = FAIL;
          else if (!last)        state_n = INPUT;
          else if (len == target) state_n = WIN;
          else                   state_n = ADD;
        end else if (to_done) begin
          state_n = FAIL;
        end
      end
      WIN, FAIL: if (phase_done) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    led = '0;
    unique case (state)
      SHOW_ON:   led = NUM_COLORS'(1) << mem[idx];
      WIN, FAIL: led = '1;
      default:   led = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (state == ADD && add_take)
      mem[len[IDX_W-1:0]] <= add_color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_FOLLOW;
      speed_q <= 1'b0;
      target  <= '0;
      len     <= '0;
      idx     <= '0;
      cnt     <= '0;
      score   <= '0;
      win     <= 1'b0;
      fail    <= 1'b0;
    end else begin
      if (state_n != state || (state == INPUT && btn_valid))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      unique case (state)
        LATCH: begin
          mode_q  <= mode ? MODE_COMMAND : MODE_FOLLOW;
          speed_q <= speed;
          target  <= target_of(level);
          len     <= '0;
          score   <= '0;
          win     <= 1'b0;
          fail    <= 1'b0;
        end
        ADD: if (add_take) begin
          len <= len + 1'b1;
          idx <= '0;
        end
        SHOW_OFF: if (phase_done) idx <= last ? '0 : idx + 1'b1;
        INPUT: if (btn_valid && hit) begin
          if (!last)
            idx <= idx + 1'b1;
          else if (score != SCORE_W'(MAX_LEN))
            score <= score + 1'b1;
        end
        default: ;
      endcase
      if (state_n == WIN && state != WIN)   win  <= 1'b1;
      if (state_n == FAIL && state != FAIL) fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Randomized bench for simon_seq_engine (3 colours, depth 16)
// against a cycle-counted game model.
module tb_simon_seq_engine;

  localparam int NC      = 3;
  localparam int PH_FAST = 4;
  localparam int PH_SLOW = 6;
  localparam int TO      = 40;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0, mode = 0, speed = 0;
  logic [1:0]  level = 0;
  logic [15:0] seed = 0;
  logic        btn_valid = 0;
  logic [1:0]  btn_color = 0;
  logic [2:0]  led;
  logic        busy, win, fail;
  logic [4:0]  score;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  int          seq[$];
  logic [15:0] seed_eff;
  int          t0;
  int          phase;

  simon_seq_engine #(
    .NUM_COLORS(NC), .MAX_LEN(16), .FAST_CYCLES(PH_FAST),
    .SLOW_CYCLES(PH_SLOW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .speed(speed), .level(level), .seed(seed),
    .btn_valid(btn_valid), .btn_color(btn_color),
    .led(led), .busy(busy), .score(score), .win(win), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, ncyc=%0d", ncyc);
    $fatal(1);
  end

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] x;
    x = s;
    for (int i = 0; i < n; i++)
      x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    return x;
  endfunction

  // colour drawn by an ADD in cycle ncyc=c (seed present from cycle t0)
  function automatic int model_color(input int c);
    logic [15:0] x;
    int v;
    x = adv(seed_eff, c - t0);
    v = int'(x % 16'd4);
    return v % NC;
  endfunction

  // leaves the bench at the negedge of the first ADD cycle
  task automatic begin_game(input logic m, input logic sp,
                            input logic [1:0] lv, input logic [15:0] sd);
    @(negedge clk);
    mode = m; speed = sp; level = lv; seed = sd; start = 1;
    t0 = ncyc + 2;
    seed_eff = (sd == 16'h0) ? 16'hACE1 : sd;
    phase = sp ? PH_FAST : PH_SLOW;
    seq.delete();
    @(negedge clk);
    start = 0;
    @(negedge clk);
    mode = ~m; speed = ~sp; level = ~lv; seed = ~sd;
  endtask

  task automatic check_show(output int bad, output logic [2:0] got,
                            output logic [2:0] want);
    logic [2:0] e;
    bad = 0; got = '0; want = '0;
    foreach (seq[k]) begin
      for (int p = 0; p < 2 * phase; p++) begin
        @(negedge clk);
        btn_valid = 0;
        e = (p < phase) ? 3'(1 << seq[k]) : 3'b000;
        if (led !== e) begin
          if (bad == 0) begin got = led; want = e; end
          bad++;
        end
      end
    end
  endtask

  // from the last SHOW_OFF negedge; ends in the cycle after the last press
  task automatic echo_seq();
    @(negedge clk);
    foreach (seq[i]) begin
      btn_valid = 1;
      btn_color = 2'(seq[i]);
      @(negedge clk);
      btn_valid = 0;
      if (i < seq.size() - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic follow_round(output int bad, output logic [2:0] got,
                              output logic [2:0] want);
    seq.push_back(model_color(ncyc));
    check_show(bad, got, want);
    echo_seq();
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({led, busy, score, win, fail} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: led=%b busy=%b score=%0d win=%b fail=%b, expected all 0",
               led, busy, score, win, fail);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_follow_win();
    int bad; logic [2:0] g, w;
    begin_game(0, 1, 2'b00, 16'($urandom_range(1, 65535)));
    n_tests++;
    if (busy !== 1'b1 || score !== 5'd0) begin
      n_fail++;
      $display("FAIL follow_start: busy=%b score=%0d, expected 1/0", busy, score);
    end
    for (int r = 1; r <= 8; r++) begin
      follow_round(bad, g, w);
      n_tests++;
      if (bad !== 0 || score !== 5'(r) || win !== (r == 8)) begin
        n_fail++;
        $display("FAIL follow_r%0d: led=%b want %b (%0d bad), score=%0d want %0d, win=%b",
                 r, g, w, bad, score, r, win);
      end
    end
    bad = 0;
    for (int p = 0; p < phase; p++) begin
      if (p > 0) @(negedge clk);
      if (led !== 3'b111) bad++;
    end
    @(negedge clk);
    n_tests++;
    if (bad !== 0 || busy !== 0 || led !== 0 || win !== 1 || fail !== 0 || score !== 5'd8) begin
      n_fail++;
      $display("FAIL follow_win_end: flash_bad=%0d busy=%b led=%b win=%b fail=%b score=%0d, expected 0/0/000/1/0/8",
               bad, busy, led, win, fail, score);
    end
  endtask

  task automatic test_wrong_color();
    int bad; logic [2:0] g, w;
    int wrong;
    begin_game(0, 0, 2'b00, 16'($urandom_range(1, 65535)));
    n_tests++;
    if (score !== 0 || win !== 0) begin
      n_fail++;
      $display("FAIL latch_clear: score=%0d win=%b, expected 0/0", score, win);
    end
    for (int r = 1; r <= 2; r++) begin
      follow_round(bad, g, w);
      n_tests++;
      if (bad !== 0 || score !== 5'(r)) begin
        n_fail++;
        $display("FAIL wrong_r%0d: led=%b want %b (%0d bad), score=%0d want %0d",
                 r, g, w, bad, score, r);
      end
    end
    seq.push_back(model_color(ncyc));
    check_show(bad, g, w);
    @(negedge clk);
    btn_valid = 1; btn_color = 2'(seq[0]);
    @(negedge clk);
    btn_valid = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    wrong = (seq[1] + 1 + $urandom_range(0, 1)) % NC;
    btn_valid = 1; btn_color = 2'(wrong);
    @(negedge clk);
    btn_valid = 0;
    n_tests++;
    if (bad !== 0 || fail !== 1 || led !== 3'b111 || score !== 5'd2 || win !== 0) begin
      n_fail++;
      $display("FAIL wrong_press: show_bad=%0d fail=%b led=%b score=%0d win=%b, expected 0/1/111/2/0",
               bad, fail, led, score, win);
    end
    bad = 0;
    repeat (phase - 1) begin
      @(negedge clk);
      if (led !== 3'b111) bad++;
    end
    @(negedge clk);
    n_tests++;
    if (bad !== 0 || busy !== 0 || fail !== 1 || score !== 5'd2 || led !== 0) begin
      n_fail++;
      $display("FAIL wrong_end: flash_bad=%0d busy=%b fail=%b score=%0d led=%b, expected 0/0/1/2/000",
               bad, busy, fail, score, led);
    end
  endtask

  task automatic test_timeout();
    int bad; logic [2:0] g, w;
    begin_game(0, 1, 2'b01, 16'($urandom_range(1, 65535)));
    seq.push_back(model_color(ncyc));
    check_show(bad, g, w);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    n_tests++;
    if (bad !== 0 || fail !== 0 || busy !== 1) begin
      n_fail++;
      $display("FAIL timeout_early: show_bad=%0d fail=%b busy=%b, expected 0/0/1", bad, fail, busy);
    end
    @(negedge clk);
    n_tests++;
    if (fail !== 1 || led !== 3'b111) begin
      n_fail++;
      $display("FAIL timeout_expire: fail=%b led=%b, expected 1/111", fail, led);
    end
    repeat (phase) @(negedge clk);
    n_tests++;
    if (busy !== 0 || fail !== 1) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b fail=%b, expected 0/1", busy, fail);
    end

    begin_game(0, 1, 2'b00, 16'($urandom_range(1, 65535)));
    seq.push_back(model_color(ncyc));
    check_show(bad, g, w);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    btn_valid = 1; btn_color = 2'(seq[0]);
    @(negedge clk);
    btn_valid = 0;
    n_tests++;
    if (fail !== 0 || score !== 5'd1) begin
      n_fail++;
      $display("FAIL expiry_press_r1: fail=%b score=%0d, expected 0/1", fail, score);
    end
    seq.push_back(model_color(ncyc));
    check_show(bad, g, w);
    @(negedge clk);
    btn_valid = 1; btn_color = 2'(seq[0]);
    @(negedge clk);
    btn_valid = 0;
    repeat (TO - 1) @(negedge clk);
    btn_valid = 1; btn_color = 2'(seq[1]);
    @(negedge clk);
    btn_valid = 0;
    n_tests++;
    if (bad !== 0 || fail !== 0 || score !== 5'd2) begin
      n_fail++;
      $display("FAIL expiry_press_r2: show_bad=%0d fail=%b score=%0d, expected 0/0/2",
               bad, fail, score);
    end
    pulse_rst();
  endtask

  task automatic test_command();
    int bad; logic [2:0] g, w;
    int cols[3] = '{2, 0, 1};
    begin_game(1, 1, 2'b00, 16'($urandom_range(1, 65535)));
    btn_valid = 1; btn_color = 2'd3;
    @(negedge clk);
    btn_valid = 0;
    repeat (TO + 10) @(negedge clk);
    n_tests++;
    if (busy !== 1 || fail !== 0 || led !== 0) begin
      n_fail++;
      $display("FAIL cmd_ignore: busy=%b fail=%b led=%b, expected 1/0/000", busy, fail, led);
    end
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      btn_valid = 1; btn_color = 2'(cols[r]);
      seq.push_back(cols[r]);
      check_show(bad, g, w);
      echo_seq();
      n_tests++;
      if (bad !== 0 || score !== 5'(r + 1) || fail !== 0) begin
        n_fail++;
        $display("FAIL cmd_r%0d: led=%b want %b (%0d bad), score=%0d want %0d, fail=%b",
                 r + 1, g, w, bad, score, r + 1, fail);
      end
    end
    pulse_rst();
  endtask

  task automatic test_long_win();
    int bad; logic [2:0] g, w;
    begin_game(0, 1, 2'(2 + $urandom_range(0, 1)), 16'($urandom_range(1, 65535)));
    for (int r = 1; r <= 16; r++) begin
      follow_round(bad, g, w);
      n_tests++;
      if (bad !== 0 || score !== 5'(r) || win !== (r == 16)) begin
        n_fail++;
        $display("FAIL long_r%0d: led=%b want %b (%0d bad), score=%0d want %0d, win=%b",
                 r, g, w, bad, score, r, win);
      end
    end
    repeat (phase) @(negedge clk);
    n_tests++;
    if (busy !== 0 || win !== 1 || score !== 5'd16) begin
      n_fail++;
      $display("FAIL long_end: busy=%b win=%b score=%0d, expected 0/1/16", busy, win, score);
    end
  endtask

  task automatic test_seed_start();
    int bad; logic [2:0] g, w;
    begin_game(0, 0, 2'b00, 16'h0000);
    follow_round(bad, g, w);
    n_tests++;
    if (bad !== 0 || score !== 5'd1) begin
      n_fail++;
      $display("FAIL seed0_r1: led=%b want %b (%0d bad), score=%0d want 1", g, w, bad, score);
    end
    seq.push_back(model_color(ncyc));
    fork
      check_show(bad, g, w);
      begin
        repeat (5) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
      end
    join
    echo_seq();
    n_tests++;
    if (bad !== 0 || score !== 5'd2 || fail !== 0) begin
      n_fail++;
      $display("FAIL start_in_show: led=%b want %b (%0d bad), score=%0d want 2, fail=%b",
               g, w, bad, score, fail);
    end
    pulse_rst();
  endtask

  task automatic test_reset_mid();
    int bad; logic [2:0] g, w;
    logic [2:0] e;
    begin_game(0, 1, 2'b00, 16'($urandom_range(1, 65535)));
    follow_round(bad, g, w);
    seq.push_back(model_color(ncyc));
    e = 3'(1 << seq[1]);
    @(negedge clk);
    n_tests++;
    if (bad !== 0 || score !== 5'd1 || led !== e) begin
      n_fail++;
      $display("FAIL mid_show: r1_bad=%0d score=%0d led=%b, expected 0/1/%b", bad, score, led, e);
    end
    #2 rst = 1;
    #1;
    n_tests++;
    if ({led, busy, score, win, fail} !== 11'b0) begin
      n_fail++;
      $display("FAIL async_reset: led=%b busy=%b score=%0d win=%b fail=%b, expected all 0",
               led, busy, score, win, fail);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || score !== 0) begin
      n_fail++;
      $display("FAIL after_reset: busy=%b score=%0d, expected 0/0", busy, score);
    end
  endtask

  initial begin
    test_reset();
    test_follow_win();
    test_wrong_color();
    test_timeout();
    test_command();
    test_long_win();
    test_seed_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
